latch_bank_ctrl: RTL

- Write controller and arbiter for a bank of NUM D-latch storage cells, each WIDTH bits, in the ALU register/operand store.
- Two requesters share the bank: requester 0 is ALU result writeback, requester 1 is the external load port. A clear command zeroes the whole bank.
- Each write is sequenced SETUP -> ENABLE -> HOLD, so latch data is stable before the latch enable rises and after it falls.

---
 rtl/latch_bank_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/latch_bank_ctrl.sv
// Write controller and round-robin arbiter for a bank of NUM WIDTH-bit D-latch cells.
// Define LATCH_BANK_CTRL_FIXED_PRIO_EN to make requester 0 always win conflicts.
module latch_bank_ctrl #(
  parameter int WIDTH  = 8,
  parameter int NUM    = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [WIDTH-1:0]  i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [WIDTH-1:0]  i_req1_data,
  output logic              o_req1_ready,
  input  logic              i_clear_req,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  output logic [WIDTH-1:0]  o_latch_d,
  output logic [NUM-1:0]    o_latch_en,
  output logic              o_busy,
  output logic              o_err_addr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ENABLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_sweep;
  logic [ADDR_W-1:0]  r_addr;
  logic [WIDTH-1:0]   r_latch_d;
  logic [NUM-1:0]     r_latch_en;
  logic               r_clear_busy;
  logic               r_clear_done;
  logic               r_err_addr;

  logic               w_arb_ok;
  logic               w_pick1;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic               w_start_clear;
  logic               w_sweep_last;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_bad;

  // Out-of-range addresses decode to an all-zero enable vector.
  function automatic logic [NUM-1:0] f_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM-1:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++) begin
      if (a == ADDR_W'(i)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  assign w_arb_ok      = i_reset && (r_state == S_IDLE) && !i_clear_req;
  assign w_start_clear = i_reset && (r_state == S_IDLE) && i_clear_req;
`ifdef LATCH_BANK_CTRL_FIXED_PRIO_EN
  assign w_pick1       = i_req1_valid && !i_req0_valid;
`else
  assign w_pick1       = i_req1_valid && (!i_req0_valid || (r_last_grant == 1'b0));
`endif
  assign w_grant1      = w_arb_ok && w_pick1;
  assign w_grant0      = w_arb_ok && i_req0_valid && !w_pick1;
  assign w_accept      = w_grant0 || w_grant1;
  assign w_sel_addr    = w_grant1 ? i_req1_addr : i_req0_addr;
  assign w_sel_data    = w_grant1 ? i_req1_data : i_req0_data;
  assign w_sel_bad     = ~|f_onehot(w_sel_addr);
  assign w_sweep_last  = (r_addr == ADDR_W'(NUM - 1));

  // Next-state logic for the SETUP/ENABLE/HOLD write sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_clear || w_accept) begin
          w_next = S_SETUP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SETUP:  w_next = S_ENABLE;
      S_ENABLE: w_next = S_HOLD;
      S_HOLD: begin
        if (r_sweep && !w_sweep_last) begin
          w_next = S_SETUP;
        end else begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // State, captured request and registered latch-side outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_sweep      <= 1'b0;
      r_addr       <= '0;
      r_latch_d    <= '0;
      r_latch_en   <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
      r_err_addr   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_clear_done <= 1'b0;
      r_err_addr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_clear) begin
            r_sweep      <= 1'b1;
            r_addr       <= '0;
            r_latch_d    <= '0;
            r_clear_busy <= 1'b1;
          end else if (w_accept) begin
            r_sweep      <= 1'b0;
            r_addr       <= w_sel_addr;
            r_latch_d    <= w_sel_data;
            r_last_grant <= w_grant1;
            r_err_addr   <= w_sel_bad;
          end
        end
        S_SETUP:  r_latch_en <= f_onehot(r_addr);
        S_ENABLE: r_latch_en <= '0;
        S_HOLD: begin
          // The data bus stays at zero between swept cells; only the index moves.
          if (r_sweep && !w_sweep_last) begin
            r_addr <= r_addr + ADDR_W'(1);
          end else if (r_sweep) begin
            r_sweep      <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b1;
          end
        end
        default: r_latch_en <= '0;
      endcase
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_clear_busy = r_clear_busy;
  assign o_clear_done = r_clear_done;
  assign o_latch_d    = r_latch_d;
  assign o_latch_en   = r_latch_en;
  assign o_busy       = (r_state != S_IDLE);
  assign o_err_addr   = r_err_addr;

endmodule
